// File: rtl/ascii_reading_parser_pkg.sv
// Shared ASCII byte codes, parser FSM states and the packed reading-word layout
// used by both this parser and the display/ASCII encoder.
package ascii_reading_parser_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int HUM_INT_LSB   = 24;
    localparam int HUM_FRAC_LSB  = 16;
    localparam int TEMP_INT_LSB  = 8;
    localparam int SIGN_BIT      = 7;
    localparam int TEMP_FRAC_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_INT,
        ST_T_FRAC,
        ST_T_SEP,
        ST_H_INT,
        ST_H_FRAC,
        ST_H_END,
        ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        CL_DIGIT,
        CL_MINUS,
        CL_DOT,
        CL_COMMA,
        CL_TERM,
        CL_SPACE,
        CL_OTHER
    } byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        byte_class_t c;
        c = CL_OTHER;
        case (b)
            ASCII_MINUS:        c = CL_MINUS;
            ASCII_DOT:          c = CL_DOT;
            ASCII_COMMA:        c = CL_COMMA;
            ASCII_CR, ASCII_LF: c = CL_TERM;
            ASCII_SPACE:        c = CL_SPACE;
            default:            c = CL_OTHER;
        endcase
        if (b >= ASCII_ZERO && b <= ASCII_NINE) begin
            c = CL_DIGIT;
        end
        return c;
    endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// Decimal integer accumulator shared by the temperature and humidity fields; state updates
// one cycle after clr/load/step, and ovf flags in advance that the next step would be illegal.
module ascii_dec_accum #(
    parameter int MAX_DIGITS = 3,
    parameter int CW         = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          clr,
    input  logic          load,
    input  logic          step,
    input  logic [3:0]    digit,
    output logic [7:0]    acc_byte,
    output logic [CW-1:0] cnt,
    output logic          ovf
);
    import ascii_reading_parser_pkg::*;

    logic [8:0]    acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   step_val;

    // acc*10 + digit, wide enough that any overflow is visible before it is stored
    assign step_val = {acc_q, 3'b000} + {2'b00, acc_q, 1'b0} + {8'h00, digit};

    assign ovf      = acc_q[8] || (cnt_q >= CW'(MAX_DIGITS)) || (step_val > 12'd255);
    assign acc_byte = acc_q[7:0];
    assign cnt      = cnt_q;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (load) begin
            acc_d = {5'b00000, digit};
            cnt_d = CW'(1);
        end else if (step) begin
            acc_d = step_val[8:0];
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ascii_reading_parser.sv
// Parses "[-]T[.t],H[.h]<CR|LF>" lines from the RX byte stream into the packed sensor word;
// result/error pulse one cycle after the deciding byte; always ready, no backpressure.
module ascii_reading_parser #(
    parameter int MAX_INT_DIGITS = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] data_valid,
    output logic        data_update,
    output logic        parse_err,
    output logic        busy
);
    import ascii_reading_parser_pkg::*;

    localparam int            CW       = (MAX_INT_DIGITS < 1) ? 1 : $clog2(MAX_INT_DIGITS + 1);
    localparam int            TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    state_t        state_q, state_d;
    byte_class_t   cls;
    logic [3:0]    digit;
    logic          byte_act;
    logic [7:0]    acc_byte;
    logic [CW-1:0] acc_cnt;
    logic          acc_empty, acc_ovf, acc_clr, acc_load, acc_step;
    logic          frame_err, commit, tmo_hit;

    logic          sign_q, sign_d;
    logic [7:0]    temp_int_q, temp_int_d;
    logic [6:0]    temp_frac_q, temp_frac_d;
    logic [7:0]    hum_frac_q, hum_frac_d;
    logic [31:0]   data_valid_q, data_valid_d;
    logic          data_update_q, data_update_d;
    logic          parse_err_q, parse_err_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign cls       = classify(rx_data);
    assign digit     = rx_data[3:0];
    assign byte_act  = rx_valid && (cls != CL_SPACE);
    assign acc_empty = (acc_cnt == '0);
    // A byte arriving on the limit cycle takes priority over the timeout
    assign tmo_hit   = TMO_EN && (state_q != ST_IDLE) && !rx_valid && (tmo_cnt_q == TMO_LAST);

    ascii_dec_accum #(
        .MAX_DIGITS (MAX_INT_DIGITS),
        .CW         (CW)
    ) u_accum (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clr      (acc_clr),
        .load     (acc_load),
        .step     (acc_step),
        .digit    (digit),
        .acc_byte (acc_byte),
        .cnt      (acc_cnt),
        .ovf      (acc_ovf)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_err = 1'b0;
        commit    = 1'b0;
        if (byte_act) begin
            case (state_q)
                ST_IDLE: begin
                    case (cls)
                        CL_MINUS, CL_DIGIT: state_d = ST_T_INT;
                        CL_TERM:            state_d = ST_IDLE;
                        default:            frame_err = 1'b1;
                    endcase
                end
                ST_T_INT: begin
                    case (cls)
                        CL_DIGIT: frame_err = acc_ovf;
                        CL_DOT:   if (acc_empty) frame_err = 1'b1; else state_d = ST_T_FRAC;
                        CL_COMMA: if (acc_empty) frame_err = 1'b1; else state_d = ST_H_INT;
                        default:  frame_err = 1'b1;
                    endcase
                end
                ST_T_FRAC: if (cls == CL_DIGIT) state_d = ST_T_SEP; else frame_err = 1'b1;
                ST_T_SEP:  if (cls == CL_COMMA) state_d = ST_H_INT; else frame_err = 1'b1;
                ST_H_INT: begin
                    case (cls)
                        CL_DIGIT: frame_err = acc_ovf;
                        CL_DOT:   if (acc_empty) frame_err = 1'b1; else state_d = ST_H_FRAC;
                        CL_TERM:  if (acc_empty) frame_err = 1'b1; else commit = 1'b1;
                        default:  frame_err = 1'b1;
                    endcase
                end
                ST_H_FRAC: if (cls == CL_DIGIT) state_d = ST_H_END; else frame_err = 1'b1;
                ST_H_END:  if (cls == CL_TERM) commit = 1'b1; else frame_err = 1'b1;
                default:   if (cls == CL_TERM) state_d = ST_IDLE;
            endcase
            if (frame_err) begin
                state_d = (cls == CL_TERM) ? ST_IDLE : ST_ERR;
            end
            if (commit) begin
                state_d = ST_IDLE;
            end
        end else if (tmo_hit) begin
            state_d   = ST_IDLE;
            frame_err = (state_q != ST_ERR);
        end
    end

    always_comb begin
        sign_d        = sign_q;
        temp_int_d    = temp_int_q;
        temp_frac_d   = temp_frac_q;
        hum_frac_d    = hum_frac_q;
        data_valid_d  = data_valid_q;
        data_update_d = commit;
        parse_err_d   = frame_err;
        acc_clr       = (state_d == ST_IDLE);
        acc_load      = 1'b0;
        acc_step      = 1'b0;

        if (byte_act && !frame_err) begin
            case (state_q)
                ST_IDLE: begin
                    if (cls == CL_MINUS) sign_d = 1'b1;
                    if (cls == CL_DIGIT) begin
                        sign_d   = 1'b0;
                        acc_load = 1'b1;
                    end
                end
                ST_T_INT: begin
                    if (cls == CL_DIGIT) acc_step = 1'b1;
                    if (cls == CL_DOT || cls == CL_COMMA) begin
                        temp_int_d = acc_byte;
                        acc_clr    = 1'b1;
                    end
                    if (cls == CL_COMMA) temp_frac_d = '0;
                end
                ST_T_FRAC: temp_frac_d = {3'b000, digit};
                ST_H_INT:  if (cls == CL_DIGIT) acc_step = 1'b1;
                ST_H_FRAC: hum_frac_d = {4'h0, digit};
                default: ;
            endcase
        end

        if (commit) begin
            data_valid_d                        = '0;
            data_valid_d[HUM_INT_LSB +: 8]      = acc_byte;
            data_valid_d[HUM_FRAC_LSB +: 8]     = (state_q == ST_H_END) ? hum_frac_q : 8'h00;
            data_valid_d[TEMP_INT_LSB +: 8]     = temp_int_q;
            // Negative zero is reported as plain zero
            data_valid_d[SIGN_BIT]              = sign_q && ((temp_int_q != '0) || (temp_frac_q != '0));
            data_valid_d[TEMP_FRAC_LSB +: 7]    = temp_frac_q;
        end

        if (!TMO_EN || rx_valid || (state_q == ST_IDLE) || tmo_hit) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sign_q        <= 1'b0;
            temp_int_q    <= '0;
            temp_frac_q   <= '0;
            hum_frac_q    <= '0;
            data_valid_q  <= '0;
            data_update_q <= 1'b0;
            parse_err_q   <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            sign_q        <= sign_d;
            temp_int_q    <= temp_int_d;
            temp_frac_q   <= temp_frac_d;
            hum_frac_q    <= hum_frac_d;
            data_valid_q  <= data_valid_d;
            data_update_q <= data_update_d;
            parse_err_q   <= parse_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign data_valid  = data_valid_q;
    assign data_update = data_update_q;
    assign parse_err   = parse_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
